// File: rtl/axi_fetch_line_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_fetch_line_unit                                          |
// | Description : Fetches one aligned line per AXI INCR burst and streams its  |
// |               instructions with their PCs; redirect flushes stale bursts.  |
// |               Optional macro FETCH_ZERO_HALT_EN halts on an all-zero word. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module axi_fetch_line_unit #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  BURST_LEN  = 8,
    parameter int                  INST_WIDTH = 32,
    parameter logic [ID_WIDTH-1:0] ARID       = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  halted
);
    localparam int C_IPB        = DATA_WIDTH / INST_WIDTH;
    localparam int C_NSLOT      = BURST_LEN * C_IPB;
    localparam int C_LINE_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int C_LINE_BITS  = BURST_LEN * DATA_WIDTH;
    localparam int C_OFF_W      = $clog2(INST_WIDTH / 8);
    localparam int C_SLOT_W     = (C_NSLOT > 1) ? $clog2(C_NSLOT) : 1;
    localparam int C_BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] C_LINE_MASK = ~ADDR_WIDTH'(C_LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] C_INST_STEP = ADDR_WIDTH'(INST_WIDTH / 8);

    typedef enum logic [2:0] {
        S_AR    = 3'd0,
        S_R     = 3'd1,
        S_EMIT  = 3'd2,
        S_FLUSH = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    inst_valid_q, inst_valid_d;
    logic                    halted_q, halted_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [C_BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [C_LINE_BITS-1:0]  line_q, line_d;

    logic [C_SLOT_W-1:0]     w_slot;
    logic                    w_slot_last;
    logic [INST_WIDTH-1:0]   w_inst;
    logic                    w_r_hs;
    logic                    w_inst_hs;
    logic                    w_zero_halt;
    logic                    w_unused;

    generate
        if (C_NSLOT > 1) begin : g_slot_idx
            assign w_slot = pc_q[C_OFF_W +: C_SLOT_W];
        end else begin : g_slot_one
            assign w_slot = '0;
        end
    endgenerate

    assign w_slot_last = (w_slot == C_SLOT_W'(C_NSLOT - 1));
    assign w_r_hs      = rready_q && m_axi_rvalid;
    assign w_inst_hs   = inst_valid_q && inst_ready;
    assign w_unused    = ^{m_axi_rid, m_axi_rresp};

`ifdef FETCH_ZERO_HALT_EN
    assign w_zero_halt = (w_inst == '0);
`else
    assign w_zero_halt = 1'b0;
`endif

    always_comb begin
        w_inst = line_q[INST_WIDTH-1:0];
        for (int s = 0; s < C_NSLOT; s++) begin
            if (w_slot == C_SLOT_W'(s)) w_inst = line_q[s*INST_WIDTH +: INST_WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        inst_valid_d = inst_valid_q;
        halted_d     = halted_q;
        flush_pend_d = flush_pend_q;
        beat_cnt_d   = beat_cnt_q;
        line_d       = line_q;
        case (state_q)
            S_AR: begin
                if (arvalid_q) begin
                    // An issued request cannot be withdrawn; a late redirect drains its burst.
                    if (m_axi_arready) begin
                        arvalid_d    = 1'b0;
                        rready_d     = 1'b1;
                        beat_cnt_d   = '0;
                        flush_pend_d = 1'b0;
                        state_d      = (flush_pend_q || redirect_valid) ? S_FLUSH : S_R;
                    end else if (redirect_valid) begin
                        flush_pend_d = 1'b1;
                    end
                end else begin
                    arvalid_d = 1'b1;
                    araddr_d  = (redirect_valid ? redirect_pc : pc_q) & C_LINE_MASK;
                end
            end
            S_R: begin
                if (w_r_hs) begin
                    for (int b = 0; b < BURST_LEN; b++) begin
                        if (beat_cnt_q == C_BEAT_W'(b)) line_d[b*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                    end
                    beat_cnt_d = (BURST_LEN > 1) ? beat_cnt_q + 1'b1 : '0;
                    if (m_axi_rlast) begin
                        rready_d     = 1'b0;
                        inst_valid_d = !redirect_valid;
                        state_d      = redirect_valid ? S_AR : S_EMIT;
                    end else if (redirect_valid) begin
                        state_d = S_FLUSH;
                    end
                end else if (redirect_valid) begin
                    state_d = S_FLUSH;
                end
            end
            S_EMIT: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    state_d      = S_AR;
                end else if (w_inst_hs) begin
                    pc_d = pc_q + C_INST_STEP;
                    if (w_zero_halt) begin
                        halted_d     = 1'b1;
                        inst_valid_d = 1'b0;
                        state_d      = S_HALT;
                    end else if (w_slot_last) begin
                        inst_valid_d = 1'b0;
                        state_d      = S_AR;
                    end
                end
            end
            S_FLUSH: begin
                if (w_r_hs && m_axi_rlast) begin
                    rready_d = 1'b0;
                    state_d  = S_AR;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    halted_d = 1'b0;
                    state_d  = S_AR;
                end
            end
            default: state_d = S_AR;
        endcase
        if (redirect_valid) pc_d = redirect_pc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_AR;
            pc_q         <= entry;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            flush_pend_q <= flush_pend_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign m_axi_arid    = ARID;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b110;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign inst_valid    = inst_valid_q;
    assign inst          = w_inst;
    assign inst_pc       = pc_q;
    assign halted        = halted_q;

endmodule
`default_nettype wire
